c17_array_bist: RTL and testbench
=================================

// Module: c17_array_bist
// PURPOSE
//  Parametrised successor to the dual-c17 NAND2 benchmark: NCH independent c17 cores behind
//  registered input/output stages, with an optional mid-pipeline register. Adds a built-in
//  self-test mode for aging experiments: an LFSR drives all cores and a MISR compacts the outputs.
//  Sits between the stress-pattern source and the delay/aging monitor.
// PARAMETERS
//  NCH     2       number of c17 channels (1..8)
//  PIPE    1       0: no internal register; 1: register after level-2 nets (N10,N16,N19)
//  LFSR_W  16      pattern LFSR width; must be >= 5*NCH
//  MISR_W  16      signature width; must be >= 2*NCH
//  NPAT    1024    patterns issued per BIST run (1..65535)
//  SEED    16'hACE1 LFSR load value on start; SEED==0 is replaced by 1
// PORTS
//  clk        in   1          single clock, all state on rising edge
//  rst_n      in   1          synchronous, active-low reset
//  mode_bist  in   1          0 functional, 1 BIST; sampled only in IDLE/DONE
//  start      in   1          BIST start pulse; honoured in IDLE/DONE when mode_bist=1
//  in_valid   in   1          functional input qualifier
//  in_vec     in   5*NCH      ch k bits[5k+4:5k] = {N7,N6,N3,N2,N1}
//  out_valid  out  1          out_vec valid this cycle
//  out_vec    out  2*NCH      ch k bits[2k+1:2k] = {N23,N22}
//  busy       out  1          high in RUN or DRAIN
//  done       out  1          high in DONE
//  signature  out  MISR_W     MISR contents; stable in DONE
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; out_vec, out_valid, busy, done, signature = 0;
//   LFSR=SEED; pattern counter=0; all pipeline valids cleared. Applies mid-run: run aborted.
//  Core logic per channel: N10=~(N1&N3) N11=~(N3&N6) N16=~(N2&N11) N19=~(N11&N7)
//   N22=~(N10&N16) N23=~(N16&N19).
//  Pipeline: input reg -> [PIPE reg] -> output reg. LAT = 2+PIPE. Input accepted at edge t
//   appears on out_vec with out_valid=1 after edge t+LAT-1 (visible cycle t+LAT-1..t+LAT).
//   Full throughput, one vector/cycle, no backpressure. Valid travels with data; out_vec
//   holds last value when out_valid=0.
//  Functional mode: in IDLE with mode_bist=0, in_vec accepted when in_valid=1.
//  FSM: IDLE -> RUN on start&mode_bist (LFSR<=SEED, MISR<=0, cnt<=0).
//   RUN: each cycle feeds LFSR[5*NCH-1:0] as in_vec (valid=1), steps LFSR, cnt++;
//    after NPAT patterns -> DRAIN. External in_valid/in_vec ignored in RUN/DRAIN.
//   DRAIN: LAT cycles, no new patterns -> DONE.
//   DONE: done=1, signature held. start&mode_bist -> RUN (restart);
//    mode_bist=0 -> IDLE (done drops). start in RUN/DRAIN ignored.
//  LFSR: Fibonacci, left shift, new bit0 = XOR of taps; W=16 taps 16,14,13,11.
//   Never reaches 0 from nonzero seed.
//  MISR (BIST only): on each out_valid, sig <= {sig[MISR_W-2:0], ^(sig & TAPMASK)} ^
//   zero-extended out_vec; same tap set as LFSR for W=16. Functional mode leaves sig untouched.
//  Timing: start sampled edge 0 -> NPAT MISR updates, last at edge NPAT+LAT ->
//   done=1 from edge NPAT+LAT+1.
//  Widths: all counters wide enough for NPAT; no arithmetic overflow paths.
// TESTING
//  1 Functional, NCH=2, PIPE=1: in_vec=10'h000 -> out_vec=4'b0000, out_valid 3 cycles later.
//  2 in_vec=10'h3FF -> out_vec=4'b0101; ch0=5'b10000 (N7 only), ch1=0 -> out_vec=4'b0010.
//  3 Back-to-back 64 random vectors, PIPE=0 and 1 -> every output matches golden c17 model
//    at LAT, no gaps/duplicates.
//  4 BIST NPAT=16: start pulse -> busy 16+LAT cycles, done at start+16+LAT+1,
//    signature equals bench LFSR/MISR model; rerun gives identical signature.
//  5 rst_n=0 mid-RUN -> next cycle all outputs 0, IDLE; fresh start reproduces signature.
//  6 start/in_valid during RUN ignored; mode_bist=0 in DONE -> IDLE, done=0, then
//    functional vectors pass.

Source files
------------

// File: rtl/c17_array_bist.sv
// NCH parallel c17 cores behind registered input/output stages, with an LFSR/MISR
// built-in self-test mode for stressing the array with pseudo-random patterns.
module c17_array_bist #(
  parameter int unsigned       NCH    = 2,
  parameter int unsigned       PIPE   = 1,
  parameter int unsigned       LFSR_W = 16,
  parameter int unsigned       MISR_W = 16,
  parameter int unsigned       NPAT   = 1024,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode_bist,
  input  logic                start,
  input  logic                in_valid,
  input  logic [5*NCH-1:0]    in_vec,
  output logic                out_valid,
  output logic [2*NCH-1:0]    out_vec,
  output logic                busy,
  output logic                done,
  output logic [MISR_W-1:0]   signature
);

  localparam int unsigned LAT  = 2 + PIPE;
  localparam int unsigned CntW = $clog2(NPAT + 1);
  localparam int unsigned InW  = 5 * NCH;
  localparam int unsigned MidW = 3 * NCH;
  localparam int unsigned OutW = 2 * NCH;

  function automatic logic [63:0] tap_mask(input int unsigned w);
    case (w)
      8:       return 64'h0000_00B8;
      10:      return 64'h0000_0240;
      12:      return 64'h0000_0829;
      16:      return 64'h0000_B400;
      20:      return 64'h0009_0000;
      24:      return 64'h00E1_0000;
      32:      return 64'h8020_0003;
      // Any feedback including the top bit is invertible, so zero stays unreachable
      default: return (64'd1 << (w - 1)) | (64'd1 << (w - 2));
    endcase
  endfunction

  localparam logic [LFSR_W-1:0] LfsrTaps = LFSR_W'(tap_mask(LFSR_W));
  localparam logic [MISR_W-1:0] MisrTaps = MISR_W'(tap_mask(MISR_W));
  localparam logic [LFSR_W-1:0] SeedEff  = (SEED == '0) ? LFSR_W'(1) : SEED;

  // Level-2 nets {N19,N16,N10} from {N7,N6,N3,N2,N1}
  function automatic logic [2:0] lvl2(input logic [4:0] x);
    logic n11;
    n11 = ~(x[2] & x[3]);
    return {~(n11 & x[4]), ~(x[1] & n11), ~(x[0] & x[2])};
  endfunction

  // Outputs {N23,N22} from {N19,N16,N10}
  function automatic logic [1:0] lvl3(input logic [2:0] m);
    return {~(m[1] & m[2]), ~(m[0] & m[1])};
  endfunction

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic [CntW-1:0]   cnt_q;
  logic [1:0]        dcnt_q;
  logic [InW-1:0]    in_q;
  logic              in_vld_q, in_tag_q, out_tag_q;
  logic [MidW-1:0]   mid_d, st2_vec;
  logic              st2_vld, st2_tag;
  logic [OutW-1:0]   out_d;
  logic              start_ok, feed_run, fn_acc;

  assign start_ok = mode_bist & start;
  assign feed_run = (state_q == StRun);
  assign fn_acc   = (state_q == StIdle) & ~mode_bist & in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lfsr_q  <= SeedEff;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state_q == StRun) || (state_q == StDrain);
      done <= (state_q == StDone);
      case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_q <= StRun;
            lfsr_q  <= SeedEff;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LfsrTaps)};
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(NPAT - 1)) begin
            state_q <= StDrain;
            dcnt_q  <= '0;
          end
        end
        StDrain: begin
          dcnt_q <= dcnt_q + 2'd1;
          if (dcnt_q == 2'(LAT - 1)) state_q <= StDone;
        end
        StDone: begin
          if (start_ok) begin
            state_q <= StRun;
            lfsr_q  <= SeedEff;
            cnt_q   <= '0;
          end else if (!mode_bist) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The tag marks BIST patterns so late functional results never reach the MISR
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q     <= '0;
      in_vld_q <= 1'b0;
      in_tag_q <= 1'b0;
    end else begin
      in_vld_q <= feed_run | fn_acc;
      in_tag_q <= feed_run;
      if (feed_run)    in_q <= lfsr_q[InW-1:0];
      else if (fn_acc) in_q <= in_vec;
    end
  end

  always_comb begin
    mid_d = '0;
    for (int c = 0; c < NCH; c++) mid_d[3*c +: 3] = lvl2(in_q[5*c +: 5]);
  end

  if (PIPE != 0) begin : g_pipe
    logic [MidW-1:0] mid_q;
    logic            mid_vld_q, mid_tag_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        mid_q     <= '0;
        mid_vld_q <= 1'b0;
        mid_tag_q <= 1'b0;
      end else begin
        mid_vld_q <= in_vld_q;
        mid_tag_q <= in_tag_q;
        if (in_vld_q) mid_q <= mid_d;
      end
    end
    assign st2_vec = mid_q;
    assign st2_vld = mid_vld_q;
    assign st2_tag = mid_tag_q;
  end else begin : g_nopipe
    assign st2_vec = mid_d;
    assign st2_vld = in_vld_q;
    assign st2_tag = in_tag_q;
  end

  always_comb begin
    out_d = '0;
    for (int c = 0; c < NCH; c++) out_d[2*c +: 2] = lvl3(st2_vec[3*c +: 3]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_tag_q <= 1'b0;
      signature <= '0;
    end else begin
      out_valid <= st2_vld;
      out_tag_q <= st2_tag;
      if (st2_vld) out_vec <= out_d;
      if (((state_q == StIdle) || (state_q == StDone)) && start_ok) begin
        signature <= '0;
      end else if (out_valid && out_tag_q) begin
        signature <= {signature[MISR_W-2:0], ^(signature & MisrTaps)} ^ MISR_W'(out_vec);
      end
    end
  end

endmodule

// File: tb/tb_c17_array_bist.sv
// Bench for c17_array_bist: PIPE=1 and PIPE=0 instances share stimulus and are checked
// against a behavioural c17 / LFSR / MISR model.
module tb_c17_array_bist;

  localparam int unsigned NCH  = 2;
  localparam int unsigned NPAT = 16;

  logic        clk = 1'b0;
  logic        rst_n, mode_bist, start, in_valid;
  logic [9:0]  in_vec;
  logic        ov1, busy1, done1, ov0, busy0, done0;
  logic [3:0]  oq1, oq0;
  logic [15:0] sig1, sig0;

  always #5 clk = ~clk;

  c17_array_bist #(.NCH(NCH), .PIPE(1), .LFSR_W(16), .MISR_W(16), .NPAT(NPAT),
                   .SEED(16'hACE1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mode_bist(mode_bist), .start(start), .in_valid(in_valid),
    .in_vec(in_vec), .out_valid(ov1), .out_vec(oq1), .busy(busy1), .done(done1),
    .signature(sig1));

  c17_array_bist #(.NCH(NCH), .PIPE(0), .LFSR_W(16), .MISR_W(16), .NPAT(NPAT),
                   .SEED(16'hACE1)) dut0 (
    .clk(clk), .rst_n(rst_n), .mode_bist(mode_bist), .start(start), .in_valid(in_valid),
    .in_vec(in_vec), .out_valid(ov0), .out_vec(oq0), .busy(busy0), .done(done0),
    .signature(sig0));

  int          total = 0;
  int          bad   = 0;
  logic        chk_stream = 1'b0;
  logic        hv [8];
  logic [3:0]  hvec [8];
  int unsigned ecnt = 0;
  logic [3:0]  last1, last0;
  logic        have1, have0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] c17(input logic [4:0] x);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
    {n7, n6, n3, n2, n1} = x;
    n10 = !(n1 && n3);
    n11 = !(n3 && n6);
    n16 = !(n2 && n11);
    n19 = !(n11 && n7);
    return {!(n16 && n19), !(n10 && n16)};
  endfunction

  function automatic logic [3:0] gold(input logic [9:0] v);
    return {c17(v[9:5]), c17(v[4:0])};
  endfunction

  function automatic logic [15:0] sig_model();
    logic [15:0] lf, ms;
    lf = 16'hACE1;
    ms = 16'h0000;
    for (int i = 0; i < NPAT; i++) begin
      ms = {ms[14:0], ms[15] ^ ms[13] ^ ms[12] ^ ms[10]} ^ {12'b0, gold(lf[9:0])};
      lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
    end
    return ms;
  endfunction

  task automatic set_chk(input logic on);
    chk_stream = on;
    have1 = 1'b0;
    have0 = 1'b0;
  endtask

  // One clock edge; the functional stream of both instances is checked after it
  task automatic tick();
    logic        acc;
    int unsigned i1, i0;
    acc = chk_stream && in_valid && !mode_bist && rst_n;
    @(posedge clk);
    hv[ecnt % 8]   = acc;
    hvec[ecnt % 8] = gold(in_vec);
    i1 = (ecnt + 6) % 8;
    i0 = (ecnt + 7) % 8;
    ecnt++;
    #1;
    if (chk_stream) begin
      chk("valid_p1", ov1, hv[i1]);
      if (hv[i1]) begin
        chk("vec_p1", oq1, hvec[i1]);
        last1 = hvec[i1];
        have1 = 1'b1;
      end else if (have1) chk("hold_p1", oq1, last1);
      chk("valid_p0", ov0, hv[i0]);
      if (hv[i0]) begin
        chk("vec_p0", oq0, hvec[i0]);
        last0 = hvec[i0];
        have0 = 1'b1;
      end else if (have0) chk("hold_p0", oq0, last0);
    end
  endtask

  // Start pulse then watch busy/done of both; noisy mode wiggles ignored inputs in RUN
  task automatic run_bist(input logic noisy, input string tag);
    logic [15:0] exp_sig;
    set_chk(1'b0);
    mode_bist = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= NPAT + 5; k++) begin
      in_vec   = 10'($urandom);
      in_valid = 1'($urandom);
      if (noisy && k <= 15) begin
        start     = 1'($urandom);
        mode_bist = 1'($urandom);
      end else begin
        start     = 1'b0;
        mode_bist = 1'b1;
      end
      tick();
      chk({tag, "_busy_p1"}, busy1, (k <= NPAT + 3) ? 1'b1 : 1'b0);
      chk({tag, "_done_p1"}, done1, (k >= NPAT + 4) ? 1'b1 : 1'b0);
      chk({tag, "_busy_p0"}, busy0, (k <= NPAT + 2) ? 1'b1 : 1'b0);
      chk({tag, "_done_p0"}, done0, (k >= NPAT + 3) ? 1'b1 : 1'b0);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    exp_sig  = sig_model();
    chk({tag, "_sig_p1"}, sig1, exp_sig);
    chk({tag, "_sig_p0"}, sig0, exp_sig);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      hv[i]   = 1'b0;
      hvec[i] = 4'h0;
    end
    rst_n     = 1'b0;
    mode_bist = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    tick();
    tick();
    chk("rst_valid", {ov1, ov0}, 2'b00);
    chk("rst_vec", {oq1, oq0}, 8'h00);
    chk("rst_busy_done", {busy1, done1, busy0, done0}, 4'b0000);
    chk("rst_sig", {sig1, sig0}, 32'h0);
    rst_n = 1'b1;
    set_chk(1'b1);

    // Known vectors back to back
    in_valid = 1'b1;
    in_vec   = 10'h000;
    tick();
    in_vec = 10'h3FF;
    tick();
    in_vec = 10'h010;
    tick();
    chk("t1_zero", {ov1, oq1}, 5'b1_0000);
    in_valid = 1'b0;
    tick();
    chk("t2_ones", {ov1, oq1}, 5'b1_0101);
    tick();
    chk("t2_n7", {ov1, oq1}, 5'b1_0010);
    tick();
    chk("t2_hold", {ov1, oq1}, 5'b0_0010);

    // Random streams: dense then gappy
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_vec   = 10'($urandom);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'($urandom);
      in_vec   = 10'($urandom);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    run_bist(1'b0, "run1");
    run_bist(1'b1, "rerun");

    // Abort a run with reset
    mode_bist = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("abort_valid", {ov1, ov0}, 2'b00);
    chk("abort_vec", {oq1, oq0}, 8'h00);
    chk("abort_busy_done", {busy1, done1, busy0, done0}, 4'b0000);
    chk("abort_sig", {sig1, sig0}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("abort_idle", {busy1, done1, busy0, done0}, 4'b0000);
    run_bist(1'b0, "fresh");

    // Leave DONE via mode_bist=0, then functional traffic must flow again
    mode_bist = 1'b0;
    in_valid  = 1'b0;
    tick();
    tick();
    chk("exit_done", {done1, done0}, 2'b00);
    chk("exit_busy", {busy1, busy0}, 2'b00);
    set_chk(1'b1);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_vec   = 10'($urandom);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("post_sig_p1", sig1, sig_model());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
